// File: rtl/dmem_ctrl.sv
// Data-memory controller: loads the input image into the external RAM, kicks the processor,
// slaves the RAM to processor loads/stores, then streams the result region back to the host.
module dmem_ctrl #(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned IN_BYTES  = 65536,
    parameter int unsigned OUT_BASE  = 65536,
    parameter int unsigned OUT_BYTES = 16384
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cmd_go,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic [7:0]        o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    input  logic [ADDR_W-1:0] i_proc_addr,
    input  logic [7:0]        i_proc_wdata,
    input  logic [1:0]        i_proc_mem,
    input  logic              i_proc_status,
    output logic              o_proc_start,
    output logic [7:0]        o_proc_rdata,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [7:0]        o_ram_wdata,
    input  logic [7:0]        i_ram_rdata,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] LastIn  = ADDR_W'(IN_BYTES - 1);
    localparam logic [ADDR_W-1:0] LastOut = ADDR_W'(OUT_BYTES - 1);
    localparam logic [ADDR_W-1:0] NumOut  = ADDR_W'(OUT_BYTES);
    localparam logic [ADDR_W-1:0] OutBase = ADDR_W'(OUT_BASE);

    typedef enum logic [2:0] {
        StIdle, StLoad, StStart, StRun, StUnload, StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [ADDR_W-1:0] r_load_cnt;
    logic [ADDR_W-1:0] r_unl_cnt;
    logic [ADDR_W-1:0] r_out_cnt;
    logic              r_rd_pend;
    logic [7:0]        r_proc_rdata;
    logic              r_unl_pend;
    logic              r_out_valid;
    logic [7:0]        r_out_data;
    logic              w_load_hs;
    logic              w_issue;
    logic              w_out_hs;

    // A read issued last cycle presents RAM data directly; the register holds it across stalls.
    assign o_out_valid  = r_out_valid | r_unl_pend;
    assign o_out_data   = r_unl_pend ? i_ram_rdata : r_out_data;
    assign o_proc_rdata = r_rd_pend ? i_ram_rdata : r_proc_rdata;
    assign w_out_hs     = o_out_valid & i_out_ready;
    assign o_busy       = (r_state != StIdle);

    always_comb begin
        w_state_d    = r_state;
        o_in_ready   = 1'b0;
        o_proc_start = 1'b0;
        o_ram_addr   = '0;
        o_ram_we     = 1'b0;
        o_ram_wdata  = '0;
        w_load_hs    = 1'b0;
        w_issue      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_cmd_go) w_state_d = StLoad;
            end
            StLoad: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_load_hs   = 1'b1;
                    o_ram_we    = 1'b1;
                    o_ram_addr  = r_load_cnt;
                    o_ram_wdata = i_in_data;
                    if (r_load_cnt == LastIn) w_state_d = StStart;
                end
            end
            StStart: begin
                o_proc_start = 1'b1;
                w_state_d    = StRun;
            end
            StRun: begin
                o_ram_addr = i_proc_addr;
                if (i_proc_mem == 2'b10) begin
                    o_ram_we    = 1'b1;
                    o_ram_wdata = i_proc_wdata;
                end
                if (i_proc_status) w_state_d = StUnload;
            end
            StUnload: begin
                o_ram_addr = OutBase + r_unl_cnt;
                // Issue only when the output slot will be free as the data arrives.
                w_issue = (r_unl_cnt != NumOut) && (!o_out_valid || i_out_ready);
                if (w_out_hs && (r_out_cnt == LastOut)) w_state_d = StDone;
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state      <= StIdle;
            r_load_cnt   <= '0;
            r_unl_cnt    <= '0;
            r_out_cnt    <= '0;
            r_rd_pend    <= 1'b0;
            r_proc_rdata <= '0;
            r_unl_pend   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && i_cmd_go) begin
                r_load_cnt <= '0;
                r_unl_cnt  <= '0;
                r_out_cnt  <= '0;
            end
            if (w_load_hs) r_load_cnt <= r_load_cnt + 1'b1;
            r_rd_pend <= (r_state == StRun) && (i_proc_mem == 2'b01) && !i_proc_status;
            if (r_rd_pend) r_proc_rdata <= i_ram_rdata;
            r_unl_pend <= w_issue;
            if (w_issue) r_unl_cnt <= r_unl_cnt + 1'b1;
            if (w_out_hs) r_out_cnt <= r_out_cnt + 1'b1;
            if (r_unl_pend && !i_out_ready) begin
                r_out_data  <= i_ram_rdata;
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk) begin
        assert (64'(OUT_BASE) + 64'(OUT_BYTES) <= (64'd1 << ADDR_W))
            else $error("result region exceeds the address space");
    end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: RAM model, write/output scoreboards, table-driven processor phase.
module tb_dmem_ctrl;

    localparam int unsigned AW = 19;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_go;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] proc_addr;
    logic [7:0]    proc_wdata;
    logic [1:0]    proc_mem;
    logic          proc_status;
    logic          proc_start;
    logic [7:0]    proc_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct {
        logic [1:0]    mem;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic          status;
        logic          exp_we;
        logic [7:0]    exp_rd;   // proc_rdata expected in the following cycle
    } vec_t;

    wr_t        wq[$];
    logic [7:0] oq[$];
    vec_t       vecs [0:15];
    logic [7:0] ram [0:63];

    always #5 clk = ~clk;

    dmem_ctrl #(
        .ADDR_W   (AW),
        .IN_BYTES (16),
        .OUT_BASE (16),
        .OUT_BYTES(4)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_cmd_go     (cmd_go),
        .i_in_data    (in_data),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .o_out_data   (out_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .i_proc_addr  (proc_addr),
        .i_proc_wdata (proc_wdata),
        .i_proc_mem   (proc_mem),
        .i_proc_status(proc_status),
        .o_proc_start (proc_start),
        .o_proc_rdata (proc_rdata),
        .o_ram_addr   (ram_addr),
        .o_ram_we     (ram_we),
        .o_ram_wdata  (ram_wdata),
        .i_ram_rdata  (ram_rdata),
        .o_busy       (busy)
    );

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_addr[5:0]] <= ram_wdata;
        ram_rdata <= ram[ram_addr[5:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && ram_we) begin
            if (wq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %h", ram_addr, ram_wdata);
            end else begin
                wr_t e;
                e = wq.pop_front();
                check("ram_write", 32'({ram_addr, ram_wdata}), 32'(e));
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (oq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: data %h", out_data);
            end else begin
                logic [7:0] e;
                e = oq.pop_front();
                check("out_byte", 32'(out_data), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go();
        cmd_go = 1'b1;
        tick();
        cmd_go = 1'b0;
    endtask

    task automatic load_bytes(input int n, input logic [7:0] base, input bit toggle);
        int cnt = 0;
        int cyc = 0;
        while (cnt < n) begin
            in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            in_data  = 8'(32'(base) + cnt);
            if (in_valid) wq.push_back({AW'(cnt), in_data});
            @(negedge clk);
            check("load_in_ready", 32'(in_ready), 32'd1);
            check("load_we", 32'(ram_we), 32'(in_valid));
            tick();
            if (in_valid) cnt++;
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    // Called in the START cycle; returns one cycle into RUN.
    task automatic start_phase();
        @(negedge clk);
        check("start_pulse", 32'(proc_start), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("start_one_cycle", 32'(proc_start), 32'd0);
        tick();
    endtask

    task automatic run_vectors(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            proc_mem    = vecs[i].mem;
            proc_addr   = vecs[i].addr;
            proc_wdata  = vecs[i].wdata;
            proc_status = vecs[i].status;
            if (vecs[i].exp_we) wq.push_back({vecs[i].addr, vecs[i].wdata});
            @(negedge clk);
            check("run_we", 32'(ram_we), 32'(vecs[i].exp_we));
            check("run_addr", 32'(ram_addr), 32'(vecs[i].addr));
            if (i > first) check("run_rdata", 32'(proc_rdata), 32'(vecs[i-1].exp_rd));
            tick();
        end
        proc_mem    = 2'b00;
        proc_status = 1'b0;
        @(negedge clk);
        check("run_rdata_hold", 32'(proc_rdata), 32'(vecs[last].exp_rd));
        check("unload_first_empty", 32'(out_valid), 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        check("outputs_drained", 32'(oq.size()), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //               mem    addr    wdata  st    we    rd_next
        vecs[0]  = '{2'b01, 19'd5,  8'h00, 1'b0, 1'b0, 8'h05};
        vecs[1]  = '{2'b00, 19'd3,  8'h00, 1'b0, 1'b0, 8'h05};
        vecs[2]  = '{2'b10, 19'd16, 8'hAA, 1'b0, 1'b1, 8'h05};
        vecs[3]  = '{2'b11, 19'd17, 8'h55, 1'b0, 1'b0, 8'h05};
        vecs[4]  = '{2'b01, 19'd16, 8'h00, 1'b0, 1'b0, 8'hAA};
        vecs[5]  = '{2'b10, 19'd16, 8'hA0, 1'b0, 1'b1, 8'hAA};
        vecs[6]  = '{2'b10, 19'd17, 8'hA1, 1'b0, 1'b1, 8'hAA};
        vecs[7]  = '{2'b10, 19'd18, 8'hA2, 1'b0, 1'b1, 8'hAA};
        vecs[8]  = '{2'b00, 19'd0,  8'h00, 1'b0, 1'b0, 8'hAA};
        vecs[9]  = '{2'b01, 19'd2,  8'h00, 1'b0, 1'b0, 8'h02};
        vecs[10] = '{2'b10, 19'd19, 8'hA3, 1'b1, 1'b1, 8'h02};
        // Second run follows a reset, so proc_rdata restarts at zero.
        vecs[11] = '{2'b10, 19'd16, 8'hB0, 1'b0, 1'b1, 8'h00};
        vecs[12] = '{2'b10, 19'd17, 8'hB1, 1'b0, 1'b1, 8'h00};
        vecs[13] = '{2'b10, 19'd18, 8'hB2, 1'b0, 1'b1, 8'h00};
        vecs[14] = '{2'b10, 19'd19, 8'hB3, 1'b0, 1'b1, 8'h00};
        vecs[15] = '{2'b01, 19'd16, 8'h00, 1'b1, 1'b0, 8'h00};

        rstn        = 1'b0;
        cmd_go      = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        proc_addr   = '0;
        proc_wdata  = '0;
        proc_mem    = 2'b00;
        proc_status = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_proc_start", 32'(proc_start), 32'd0);
        check("rst_proc_rdata", 32'(proc_rdata), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rstn = 1'b1;

        // Run A: continuous load, processor table, stalled unload.
        pulse_go();
        load_bytes(16, 8'h00, 1'b0);
        start_phase();
        out_ready = 1'b1;
        oq.push_back(8'hA0);
        oq.push_back(8'hA1);
        oq.push_back(8'hA2);
        oq.push_back(8'hA3);
        run_vectors(0, 10);
        tick();
        @(negedge clk);
        check("unl_a_valid0", 32'(out_valid), 32'd1);
        check("unl_a_data0", 32'(out_data), 32'hA0);
        tick();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'hA1);
            tick();
        end
        out_ready = 1'b1;
        wait_idle(20);

        // Run B: toggled load aborted by reset, then a fresh load from address 0.
        pulse_go();
        load_bytes(7, 8'h10, 1'b1);
        rstn = 1'b0;
        tick();
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we", 32'(ram_we), 32'd0);
        tick();
        rstn     = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (3) begin
            @(negedge clk);
            check("post_abort_ready", 32'(in_ready), 32'd0);
            check("post_abort_we", 32'(ram_we), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check("abort_writes_done", 32'(wq.size()), 32'd0);
        pulse_go();
        load_bytes(16, 8'h40, 1'b1);
        start_phase();
        oq.push_back(8'hB0);
        oq.push_back(8'hB1);
        oq.push_back(8'hB2);
        oq.push_back(8'hB3);
        run_vectors(11, 15);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("unl_b_valid", 32'(out_valid), 32'd1);
            check("unl_b_data", 32'(out_data), 32'(8'hB0 + k));
        end
        wait_idle(10);
        check("writes_drained", 32'(wq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the downsampling processor.
- Owns the external synchronous image RAM and services the processor's MEM load/store requests on the 19-bit data address bus.
- Around each run it sequences three phases: stream the input image in from the host, pulse processor_start, then stream the downsampled result back to the host once the processor reports status.

Parameters:
ADDR_W, 19, RAM/processor data address width
IN_BYTES, 65536, input image size in bytes, loaded at address 0 upward
OUT_BASE, 65536, first address of the result region
OUT_BYTES, 16384, result size in bytes

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous active-low reset
cmd_go  in  1  one-cycle pulse; starts a LOAD/RUN/UNLOAD sequence, honoured only in IDLE
in_data  in  8  host image byte
in_valid  in  1  host byte valid
in_ready  out  1  controller accepts byte
out_data  out  8  result byte to host
out_valid  out  1  result byte valid
out_ready  in  1  host accepts result byte
proc_addr  in  ADDR_W  processor data address (write_addr)
proc_wdata  in  8  processor store data
proc_mem  in  2  00 none, 01 load, 10 store, 11 treated as none
proc_status  in  1  processor done flag
proc_start  out  1  processor_start pulse
proc_rdata  out  8  processor read_data
ram_addr  out  ADDR_W  RAM address
ram_we  out  1  RAM write enable
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data, valid one cycle after address
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (rstn low at a clock edge): state IDLE, in_ready 0, out_valid 0, out_data 0, proc_start 0, proc_rdata 0, ram_we 0, ram_addr 0, ram_wdata 0, busy 0, all counters 0. Reset mid-sequence aborts immediately; no further RAM writes occur after that edge.
- IDLE: waits for cmd_go, then enters LOAD. cmd_go in any other state is ignored.
- LOAD: in_ready=1. Each in_valid&in_ready cycle issues a same-cycle RAM write: ram_we=1, ram_addr=load_cnt, ram_wdata=in_data; then load_cnt increments. After byte IN_BYTES-1 is accepted: in_ready drops next cycle and the state moves to START. in_valid=0 stalls with no write.
- START: proc_start=1 for exactly one cycle, then RUN.
- RUN: RAM port is slaved combinationally to the processor.
  - ram_addr=proc_addr.
  - proc_mem=10: ram_we=1, ram_wdata=proc_wdata.
  - proc_mem=01: read issued. proc_rdata=ram_rdata in the following cycle, then held in a register until the next load completes.
  - 00/11: ram_we=0.
  - When proc_status is high: ignore proc_mem and go to UNLOAD. The store seen in the same cycle as status rising is still performed.
- UNLOAD: single output register, one RAM read in flight maximum.
  - Read OUT_BASE+unl_cnt is issued when the output register is empty, or is being emptied this cycle (out_valid&out_ready).
  - Data lands in out_data with out_valid=1 the next cycle.
  - out_data/out_valid are held stable while out_ready=0.
  - Sustained throughput is 1 byte/cycle when out_ready stays high.
  - After the handshake of byte OUT_BYTES-1, go to DONE.
- DONE: one cycle, out_valid=0, then IDLE.
- Counters are ADDR_W bits wide with no wrap within legal parameters. OUT_BASE+OUT_BYTES ≤ 2^ADDR_W is required, and is checked by a simulation-only assertion.
- Outside RUN, ram_we is driven only by LOAD handshakes. Processor requests outside RUN are ignored.

Test Plan:
- Params IN_BYTES=16, OUT_BASE=16, OUT_BYTES=4. Reset, cmd_go, stream bytes 0x00..0x0F with in_valid held high -> 16 consecutive writes to addresses 0..15, in_ready low after the 16th, proc_start high for one cycle.
- LOAD with in_valid toggled 1,0,1,0 -> writes only on valid cycles, addresses contiguous, no duplicates.
- RUN: proc_mem=01 addr 5 -> proc_rdata=0x05 the next cycle and held. proc_mem=10 addr 16 data 0xAA -> RAM[16]=0xAA. proc_mem=11 -> no write.
- Processor stores 0xA0..0xA3 to 16..19, then proc_status=1; out_ready held high -> out_data A0,A1,A2,A3 on consecutive cycles, then IDLE, busy=0.
- UNLOAD with out_ready low for 3 cycles on the second byte -> out_data stays A1 with out_valid high, no byte lost or repeated.
- rstn low mid-LOAD (after 7 bytes) -> state IDLE next edge, in_ready 0, no further writes. A new cmd_go reloads from address 0.
